bp_me_wormhole_packet_serializer: RTL

- Sits directly downstream of the BedRock-to-wormhole header encoder, before the router link.
- Accepts one encoded wormhole header {msg_hdr, len, cord}, cid inside the msg/rtr header per layout, and zero or more data beats.
- Emits the packet as a flit stream on a valid/ready_and link: header flits first, then data flits.
- The number of flits sent is taken from the header's zero-based len field.

---
 rtl/bp_me_wormhole_packet_serializer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bp_me_wormhole_packet_serializer.sv
// Serializes one encoded wormhole header plus its data beats into a flit stream.
// Optional sticky length check: define BP_ME_WORMHOLE_SERIALIZER_LEN_CHECK_EN.
module bp_me_wormhole_packet_serializer #(
    parameter int flit_width_p   = 64,
    parameter int cord_width_p   = 7,
    parameter int len_width_p    = 4,
    parameter int wh_hdr_width_p = 150,
    parameter int data_width_p   = 128
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [wh_hdr_width_p-1:0] wh_header_i,
    input  logic                      header_v_i,
    output logic                      header_ready_and_o,
    input  logic [data_width_p-1:0]   data_i,
    input  logic                      data_v_i,
    output logic                      data_ready_and_o,
    output logic [flit_width_p-1:0]   link_data_o,
    output logic                      link_v_o,
    input  logic                      link_ready_and_i,
    output logic                      error_o
);

    localparam int hdr_flits_lp   = (wh_hdr_width_p + flit_width_p - 1) / flit_width_p;
    localparam int beat_flits_lp  = data_width_p / flit_width_p;
    localparam int hdr_idx_w_lp   = (hdr_flits_lp > 1) ? $clog2(hdr_flits_lp) : 1;
    localparam int beat_idx_w_lp  = (beat_flits_lp > 1) ? $clog2(beat_flits_lp) : 1;
    localparam int hdr_slots_lp   = 1 << hdr_idx_w_lp;
    localparam int beat_slots_lp  = 1 << beat_idx_w_lp;

    localparam logic [len_width_p:0]   hdr_flits_ext = (len_width_p+1)'(hdr_flits_lp);
    localparam logic [len_width_p:0]   one_ext       = (len_width_p+1)'(1);
    localparam logic [len_width_p-1:0] hdr_last_lp   = len_width_p'(hdr_flits_lp - 1);
    localparam logic [len_width_p-1:0] beat_last_lp  = len_width_p'(beat_flits_lp - 1);

    typedef enum logic [1:0] {e_ready, e_hdr, e_data} state_e;

    state_e                    state_reg, state_next;
    logic [wh_hdr_width_p-1:0] header_reg;
    logic [len_width_p-1:0]    len_reg;
    logic [len_width_p-1:0]    flit_cnt_reg, flit_cnt_next;
    logic [len_width_p-1:0]    data_cnt_reg, data_cnt_next;
    logic [len_width_p-1:0]    beat_cnt_reg, beat_cnt_next;

    logic [flit_width_p-1:0]   hdr_flit  [hdr_slots_lp];
    logic [flit_width_p-1:0]   data_flit [beat_slots_lp];

    // Header flits beyond the encoded width are zero-padded; unused slots read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < hdr_slots_lp; gi++) begin : g_hdr_flit
            if ((gi + 1) * flit_width_p <= wh_hdr_width_p) begin : g_full
                assign hdr_flit[gi] = header_reg[gi*flit_width_p +: flit_width_p];
            end else if (gi * flit_width_p < wh_hdr_width_p) begin : g_part
                assign hdr_flit[gi] = {{((gi+1)*flit_width_p - wh_hdr_width_p){1'b0}},
                                       header_reg[wh_hdr_width_p-1:gi*flit_width_p]};
            end else begin : g_none
                assign hdr_flit[gi] = '0;
            end
        end
        for (gi = 0; gi < beat_slots_lp; gi++) begin : g_data_flit
            if (gi < beat_flits_lp) begin : g_used
                assign data_flit[gi] = data_i[gi*flit_width_p +: flit_width_p];
            end else begin : g_unused
                assign data_flit[gi] = '0;
            end
        end
    endgenerate

    logic [len_width_p:0] len_ext, len_plus1, data_last_idx;
    logic                 last_data_flit, beat_last, header_accept;

    // Extra top bit keeps len - hdr_flits from silently wrapping on short packets.
    assign len_ext        = {1'b0, len_reg};
    assign len_plus1      = len_ext + one_ext;
    assign data_last_idx  = len_ext - hdr_flits_ext;
    assign last_data_flit = ({1'b0, data_cnt_reg} == data_last_idx);
    assign beat_last      = (beat_cnt_reg == beat_last_lp);

    assign header_ready_and_o = (state_reg == e_ready) & ~reset_i;
    assign header_accept      = header_ready_and_o & header_v_i;

    always_comb begin
        state_next       = state_reg;
        flit_cnt_next    = flit_cnt_reg;
        data_cnt_next    = data_cnt_reg;
        beat_cnt_next    = beat_cnt_reg;
        link_v_o         = 1'b0;
        link_data_o      = '0;
        data_ready_and_o = 1'b0;
        case (state_reg)
            e_ready: begin
                if (header_accept) begin
                    flit_cnt_next = '0;
                    state_next    = e_hdr;
                end
            end
            e_hdr: begin
                link_v_o    = ~reset_i;
                link_data_o = hdr_flit[flit_cnt_reg[hdr_idx_w_lp-1:0]];
                if (link_ready_and_i) begin
                    flit_cnt_next = flit_cnt_reg + 1'b1;
                    if (flit_cnt_reg == hdr_last_lp) begin
                        if (len_plus1 > hdr_flits_ext) begin
                            data_cnt_next = '0;
                            beat_cnt_next = '0;
                            state_next    = e_data;
                        end else begin
                            state_next = e_ready;
                        end
                    end
                end
            end
            e_data: begin
                link_v_o         = data_v_i & ~reset_i;
                link_data_o      = data_flit[beat_cnt_reg[beat_idx_w_lp-1:0]];
                data_ready_and_o = link_ready_and_i & (beat_last | last_data_flit) & ~reset_i;
                if (data_v_i & link_ready_and_i) begin
                    data_cnt_next = data_cnt_reg + 1'b1;
                    beat_cnt_next = beat_last ? '0 : beat_cnt_reg + 1'b1;
                    if (last_data_flit) begin
                        state_next = e_ready;
                    end
                end
            end
            default: state_next = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg    <= e_ready;
            header_reg   <= '0;
            len_reg      <= '0;
            flit_cnt_reg <= '0;
            data_cnt_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            flit_cnt_reg <= flit_cnt_next;
            data_cnt_reg <= data_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            if (header_accept) begin
                header_reg <= wh_header_i;
                len_reg    <= wh_header_i[cord_width_p +: len_width_p];
            end
        end
    end

`ifdef BP_ME_WORMHOLE_SERIALIZER_LEN_CHECK_EN
    logic                 error_reg;
    logic [len_width_p:0] len_in_plus1;

    assign len_in_plus1 = {1'b0, wh_header_i[cord_width_p +: len_width_p]} + one_ext;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_reg <= 1'b0;
        end else if (header_accept && (len_in_plus1 < hdr_flits_ext)) begin
            error_reg <= 1'b1;
        end
    end

    assign error_o = error_reg & ~reset_i;
`else
    assign error_o = 1'b0;
`endif

endmodule
